// File: rtl/isf_pkg.sv
// isf_pkg: shared types and constants for image_stream_filter.
// Holds the mode encoding, the 3x3 kernel coefficients and the FIFO constants.
package isf_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_SOBEL = 2'd2,
        MODE_PASS3 = 2'd3
    } mode_e;

    // Coefficients are indexed [row][col]; row 0 is the oldest line and
    // col 0 the oldest column of the window.
    localparam int GAUSS_K [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    localparam int GAUSS_SHIFT    = 4;

    localparam int SOBEL_X [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int SOBEL_Y [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    // Headroom kept in the output FIFO for results already in flight.
    localparam int PROG_FULL_MARGIN = 4;

    // Cycles from window-completing accept to FIFO write.
    localparam int PIPE_LAT = 2;
    // Cycles from FIFO write to the entry being visible on the master side.
    localparam int FIFO_LAT = 1;

endpackage

// File: rtl/isf_out_fifo.sv
// isf_out_fifo: output FIFO with programmable-full and sticky overflow.
// Ports: clk/rst, wr_en/wr_data, rd_en/rd_data (show-ahead, 0 when empty),
// empty, prog_full (occupancy >= OUT_DEPTH-PROG_FULL_MARGIN), overflow.
module isf_out_fifo
    import isf_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int OUT_DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [PIX_W-1:0] rd_data,
    output logic             empty,
    output logic             prog_full,
    output logic             overflow
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(OUT_DEPTH);
    localparam logic [AW:0] PF_C =
        (AW+1)'(OUT_DEPTH - PROG_FULL_MARGIN);

    logic [PIX_W-1:0] mem [OUT_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign prog_full = (count >= PF_C);
    assign do_rd     = rd_en && !empty;
    // A full FIFO can still take a write in the cycle it is read.
    assign do_wr     = wr_en && (!full || do_rd);
    assign rd_data   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && !do_wr) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_stream_filter.sv
// image_stream_filter: 3x3 streaming image filter (pass / gauss / sobel).
// Ports: axi_clk, axi_reset (async high), i_mode, slave i_data_valid/i_data/
// o_data_ready, master o_data_valid/o_data/i_data_ready, o_intr (end of
// frame pulse), o_overflow (sticky). Sobel needs IMAGE_STREAM_FILTER_SOBEL_EN;
// without it mode 2 passes the window centre through.
module image_stream_filter
    import isf_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int IMG_W     = 512,
    parameter int IMG_H     = 512,
    parameter int OUT_DEPTH = 32
) (
    input  logic             axi_clk,
    input  logic             axi_reset,
    input  logic [1:0]       i_mode,
    input  logic             i_data_valid,
    input  logic [PIX_W-1:0] i_data,
    output logic             o_data_ready,
    output logic             o_data_valid,
    output logic [PIX_W-1:0] o_data,
    input  logic             i_data_ready,
    output logic             o_intr,
    output logic             o_overflow
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int ACC_W = PIX_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic signed [ACC_W-1:0] acc_t;

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             accept;
    logic [PIX_W-1:0] lb_mid [IMG_W];
    logic [PIX_W-1:0] lb_top [IMG_W];
    logic [PIX_W-1:0] win [3][3];
    logic             v1;
    logic             v2;
    mode_e            mode1;
    logic [PIX_W-1:0] kern;
    logic [PIX_W-1:0] res2;
    logic [PIX_W-1:0] gauss_pix;
    logic [PIX_W-1:0] sobel_pix;
    logic             fifo_empty;
    logic             fifo_pf;

    assign accept       = i_data_valid && o_data_ready;
    assign o_data_ready = !fifo_pf;
    assign o_data_valid = !fifo_empty;

    function automatic acc_t ext(input logic [PIX_W-1:0] p);
        return acc_t'({4'b0000, p});
    endfunction

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            col    <= '0;
            row    <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            o_intr <= 1'b0;
            mode1  <= MODE_PASS;
        end else begin
            o_intr <= accept && (col == COL_LAST) && (row == ROW_LAST);
            v1     <= accept && (row >= RW'(2)) && (col >= CW'(2));
            v2     <= v1;
            if (accept) begin
                mode1 <= mode_e'(i_mode);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Line buffers shift one line down per accept at the same column, so
    // the window columns are complete with no gap between lines.
    always_ff @(posedge axi_clk) begin
        if (accept) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= i_data;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb_top[col];
            win[1][2] <= lb_mid[col];
            win[2][2] <= i_data;
        end
        if (v1) begin
            res2 <= kern;
        end
    end

    acc_t gsum;

    always_comb begin
        gsum = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                gsum = gsum + acc_t'(GAUSS_K[i][j]) * ext(win[i][j]);
            end
        end
        gauss_pix = PIX_W'(gsum >>> GAUSS_SHIFT);
    end

`ifdef IMAGE_STREAM_FILTER_SOBEL_EN
    acc_t gx;
    acc_t gy;
    acc_t ax;
    acc_t ay;
    acc_t mag;

    always_comb begin
        gx = '0;
        gy = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                gx = gx + acc_t'(SOBEL_X[i][j]) * ext(win[i][j]);
                gy = gy + acc_t'(SOBEL_Y[i][j]) * ext(win[i][j]);
            end
        end
        ax  = gx[ACC_W-1] ? -gx : gx;
        ay  = gy[ACC_W-1] ? -gy : gy;
        mag = ax + ay;
        sobel_pix = (|mag[ACC_W-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
    end
`else
    assign sobel_pix = win[1][1];
`endif

    always_comb begin
        kern = win[1][1];
        case (mode1)
            MODE_GAUSS: kern = gauss_pix;
            MODE_SOBEL: kern = sobel_pix;
            default:    kern = win[1][1];
        endcase
    end

    isf_out_fifo #(
        .PIX_W     (PIX_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (axi_clk),
        .rst       (axi_reset),
        .wr_en     (v2),
        .wr_data   (res2),
        .rd_en     (i_data_ready),
        .rd_data   (o_data),
        .empty     (fifo_empty),
        .prog_full (fifo_pf),
        .overflow  (o_overflow)
    );

endmodule

// File: tb/tb_image_stream_filter.sv
// tb_image_stream_filter: randomized self-checking bench for image_stream_filter.
// Reference results come from a plain arithmetic 3x3 model over a frame array.
module tb_image_stream_filter;

    localparam int PIX_W     = 8;
    localparam int IMG_W     = 8;
    localparam int IMG_H     = 4;
    localparam int OUT_DEPTH = 8;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int NRES      = (IMG_W - 2) * (IMG_H - 2);

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       i_mode;
    logic             i_data_valid;
    logic [PIX_W-1:0] i_data;
    logic             o_data_ready;
    logic             o_data_valid;
    logic [PIX_W-1:0] o_data;
    logic             i_data_ready;
    logic             o_intr;
    logic             o_overflow;

    image_stream_filter #(
        .PIX_W     (PIX_W),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .axi_clk      (clk),
        .axi_reset    (rst),
        .i_mode       (i_mode),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .i_data_ready (i_data_ready),
        .o_intr       (o_intr),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int intr_cnt = 0;
    int intr_cyc = -1;
    int stab_err = 0;
    int last_acc_cyc = -1;
    int img [IMG_H][IMG_W];
    logic [PIX_W-1:0] got_q[$];
    logic [PIX_W-1:0] exp_q[$];
    logic             hold_pend = 1'b0;
    logic [PIX_W-1:0] hold_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change #1 after posedge, so negedge sees what the next edge uses.
    always @(negedge clk) begin
        if (o_intr === 1'b1) begin
            intr_cnt++;
            intr_cyc = cyc;
        end
        if (hold_pend && (o_data_valid !== 1'b1 || o_data !== hold_data))
            stab_err++;
        hold_pend = (o_data_valid === 1'b1) && !i_data_ready && !rst;
        hold_data = o_data;
        if (o_data_valid === 1'b1 && i_data_ready === 1'b1)
            got_q.push_back(o_data);
    end

    function automatic logic [PIX_W-1:0] model(input int r, input int c,
                                                input int m);
        int p [3][3];
        int gx;
        int gy;
        int s;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][c-2+j];
        if (m == 1) begin
            s = p[0][0] + 2*p[0][1] + p[0][2]
              + 2*p[1][0] + 4*p[1][1] + 2*p[1][2]
              + p[2][0] + 2*p[2][1] + p[2][2];
            return PIX_W'(s / 16);
        end
`ifdef IMAGE_STREAM_FILTER_SOBEL_EN
        if (m == 2) begin
            gx = (p[0][2] + 2*p[1][2] + p[2][2])
               - (p[0][0] + 2*p[1][0] + p[2][0]);
            gy = (p[2][0] + 2*p[2][1] + p[2][2])
               - (p[0][0] + 2*p[0][1] + p[0][2]);
            s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            return (s > 255) ? 8'd255 : PIX_W'(s);
        end
`endif
        return PIX_W'(p[1][1]);
    endfunction

    task automatic send_frame(input int npix, input int fmode,
                              input bit rmode, input bit rrdy,
                              input int gap);
        for (int k = 0; k < npix; k++) begin
            int r;
            int c;
            int m;
            bit ok;
            bit acc;
            r = k / IMG_W;
            c = k % IMG_W;
            m = rmode ? int'($urandom_range(0, 3)) : fmode;
            for (int g = 0; g < 4; g++) begin
                if (int'($urandom_range(0, 99)) >= gap) break;
                i_data_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            i_data       = PIX_W'(img[r][c]);
            i_mode       = 2'(m);
            i_data_valid = 1'b1;
            ok           = 1'b0;
            for (int w = 0; w < 300 && !ok; w++) begin
                @(negedge clk);
                acc = o_data_ready;
                @(posedge clk);
                #1;
                if (acc) ok = 1'b1;
                if (rrdy) i_data_ready = ($urandom_range(0, 3) != 0);
            end
            i_data_valid = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL accept_timeout pixel %0d got no ready required accept", k);
            end else begin
                last_acc_cyc = cyc;
                if (r >= 2 && c >= 2) exp_q.push_back(model(r, c, m));
            end
        end
    endtask

    task automatic drain(input int n);
        i_data_ready = 1'b1;
        for (int i = 0; i < 300 && got_q.size() < n; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        i_data_valid = 1'b0;
        i_data       = '0;
        i_mode       = 2'd0;
        i_data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b required 0", o_data_valid);
        end
        checks++;
        if (o_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %0d required 0", o_data);
        end
        checks++;
        if (o_intr !== 1'b0) begin
            errors++;
            $display("FAIL reset_intr got %b required 0", o_intr);
        end
        checks++;
        if (o_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", o_data_ready);
        end
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b required 0", o_overflow);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_flat_gauss;
        int gb = got_q.size();
        int ib = intr_cnt;
        exp_q.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = 100;
        send_frame(NPIX, 1, 1'b0, 1'b0, 0);
        drain(gb + NRES);
        checks++;
        if (got_q.size() - gb !== NRES) begin
            errors++;
            $display("FAIL flat_count got %0d required %0d", got_q.size() - gb, NRES);
        end
        for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[gb+i] !== 8'd100 || got_q[gb+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL flat_pix %0d got %0d required %0d", i, got_q[gb+i], exp_q[i]);
            end
        end
        checks++;
        if (intr_cnt - ib !== 1) begin
            errors++;
            $display("FAIL flat_intr_count got %0d required 1", intr_cnt - ib);
        end
        checks++;
        if (intr_cyc !== last_acc_cyc) begin
            errors++;
            $display("FAIL flat_intr_cycle got %0d required %0d", intr_cyc, last_acc_cyc);
        end
    endtask

    task automatic test_vertical_edge;
        int gb = got_q.size();
        exp_q.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = (c < 4) ? 0 : 200;
        send_frame(NPIX, 2, 1'b0, 1'b0, 0);
        drain(gb + NRES);
        checks++;
        if (got_q.size() - gb !== NRES) begin
            errors++;
            $display("FAIL edge_count got %0d required %0d", got_q.size() - gb, NRES);
        end
        for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL edge_pix %0d got %0d required %0d", i, got_q[gb+i], exp_q[i]);
            end
        end
`ifdef IMAGE_STREAM_FILTER_SOBEL_EN
        checks++;
        if (got_q.size() > gb + 3 &&
            (got_q[gb+2] !== 8'd255 || got_q[gb+3] !== 8'd255)) begin
            errors++;
            $display("FAIL edge_sat got %0d,%0d required 255,255", got_q[gb+2], got_q[gb+3]);
        end
`endif
    endtask

    task automatic test_ramp_pass;
        int gb = got_q.size();
        exp_q.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = r * IMG_W + c;
        send_frame(NPIX, 0, 1'b0, 1'b0, 0);
        drain(gb + NRES);
        checks++;
        if (got_q.size() - gb !== NRES) begin
            errors++;
            $display("FAIL ramp_count got %0d required %0d", got_q.size() - gb, NRES);
        end
        checks++;
        if (got_q.size() > gb && got_q[gb] !== 8'd9) begin
            errors++;
            $display("FAIL ramp_first got %0d required 9", got_q[gb]);
        end
        for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ramp_pix %0d got %0d required %0d", i, got_q[gb+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        int gb = got_q.size();
        int ib = intr_cnt;
        exp_q.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = int'($urandom_range(0, 255));
        send_frame(NPIX, 0, 1'b1, 1'b1, 30);
        drain(gb + NRES);
        checks++;
        if (got_q.size() - gb !== NRES) begin
            errors++;
            $display("FAIL rand_count got %0d required %0d", got_q.size() - gb, NRES);
        end
        for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_pix %0d got %0d required %0d", i, got_q[gb+i], exp_q[i]);
            end
        end
        checks++;
        if (intr_cnt - ib !== 1) begin
            errors++;
            $display("FAIL rand_intr got %0d required 1", intr_cnt - ib);
        end
    endtask

    task automatic test_back_to_back;
        int gb = got_q.size();
        int ib = intr_cnt;
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < IMG_H; r++)
                for (int c = 0; c < IMG_W; c++) img[r][c] = int'($urandom_range(0, 255));
            send_frame(NPIX, 0, 1'b1, f == 1, 0);
        end
        drain(gb + 2 * NRES);
        checks++;
        if (got_q.size() - gb !== 2 * NRES) begin
            errors++;
            $display("FAIL b2b_count got %0d required %0d", got_q.size() - gb, 2 * NRES);
        end
        for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_pix %0d got %0d required %0d", i, got_q[gb+i], exp_q[i]);
            end
        end
        checks++;
        if (intr_cnt - ib !== 2) begin
            errors++;
            $display("FAIL b2b_intr got %0d required 2", intr_cnt - ib);
        end
    endtask

    task automatic test_backpressure;
        int gb = got_q.size();
        int sb = stab_err;
        exp_q.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = int'($urandom_range(0, 255));
        i_data_ready = 1'b0;
        fork
            send_frame(NPIX, 1, 1'b0, 1'b0, 0);
            begin
                repeat (80) @(posedge clk);
                #1;
                checks++;
                if (o_data_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready got %b required 0", o_data_ready);
                end
                checks++;
                if (o_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ovf_stall got %b required 0", o_overflow);
                end
                checks++;
                if (got_q.size() - gb !== 0) begin
                    errors++;
                    $display("FAIL bp_leak got %0d required 0", got_q.size() - gb);
                end
                i_data_ready = 1'b1;
            end
        join
        drain(gb + NRES);
        checks++;
        if (got_q.size() - gb !== NRES) begin
            errors++;
            $display("FAIL bp_count got %0d required %0d", got_q.size() - gb, NRES);
        end
        for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_pix %0d got %0d required %0d", i, got_q[gb+i], exp_q[i]);
            end
        end
        checks++;
        if (stab_err - sb !== 0) begin
            errors++;
            $display("FAIL bp_hold_stable got %0d required 0", stab_err - sb);
        end
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_ovf got %b required 0", o_overflow);
        end
    endtask

    task automatic test_reset_midframe;
        int gb = got_q.size();
        int ib;
        exp_q.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = int'($urandom_range(0, 255));
        send_frame(14, 0, 1'b1, 1'b0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (got_q.size() - gb !== 0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_partial got %0d required 0", got_q.size() - gb);
        end
        gb = got_q.size();
        ib = intr_cnt;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = int'($urandom_range(0, 255));
        send_frame(NPIX, 0, 1'b1, 1'b0, 10);
        drain(gb + NRES);
        checks++;
        if (got_q.size() - gb !== NRES) begin
            errors++;
            $display("FAIL mid_count got %0d required %0d", got_q.size() - gb, NRES);
        end
        for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_pix %0d got %0d required %0d", i, got_q[gb+i], exp_q[i]);
            end
        end
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_ovf got %b required 0", o_overflow);
        end
        checks++;
        if (intr_cnt - ib !== 1) begin
            errors++;
            $display("FAIL mid_intr got %0d required 1", intr_cnt - ib);
        end
    endtask

    initial begin
        test_reset();
        test_flat_gauss();
        test_vertical_edge();
        test_ramp_pass();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
